// File: rtl/mouse_cell_tracker_pkg.sv
// drawing_pkg: grid geometry, tracker FSM states and PS/2 status-bit layout shared by the drawing blocks
package drawing_pkg;
  localparam int CELL_DIMENSION = 5;
  localparam int GRID_W = 160 / CELL_DIMENSION;
  localparam int GRID_H = 120 / CELL_DIMENSION;
  localparam int UPPER_BITS = $clog2(GRID_W > GRID_H ? GRID_W : GRID_H);
  typedef enum logic [1:0] {B0, B1, B2, UPD} state_t;
  localparam int ST_L = 0;
  localparam int ST_R = 1;
  localparam int ST_ONE = 3;
  localparam int ST_XS = 4;
  localparam int ST_YS = 5;
  localparam int ST_XO = 6;
  localparam int ST_YO = 7;
  localparam logic [7:0] ACK_BYTE = 8'hFA;
endpackage

// File: rtl/mouse_cell_tracker_if.sv
// mouse_cell_tracker_if: PS/2 byte stream in, cursor cell and button state out
interface mouse_cell_tracker_if;
  import drawing_pkg::*;
  logic [7:0] iByte;
  logic iByteValid;
  logic iEnable;
  logic [UPPER_BITS-1:0] oX_cell;
  logic [UPPER_BITS-1:0] oY_cell;
  logic oBtnL;
  logic oBtnR;
  logic oPacketValid;
  logic oSyncError;
  modport master (output iByte, iByteValid, iEnable, input oX_cell, oY_cell, oBtnL, oBtnR, oPacketValid, oSyncError);
  modport slave (input iByte, iByteValid, iEnable, output oX_cell, oY_cell, oBtnL, oBtnR, oPacketValid, oSyncError);
endinterface

// File: rtl/mouse_cell_tracker_axis.sv
// axis_accumulator: sub-cell residue plus clamped (or CURSOR_WRAP_EN wrapped) cell position for one axis
module axis_accumulator #(
  parameter int GRID = 32,
  parameter int SENS_SHIFT = 3,
  parameter int W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_upd,
  input  logic signed [9:0]   i_delta,
  output logic [W-1:0]        o_pos
);
  localparam logic signed [12:0] LIM = 13'(GRID - 1);
  localparam logic signed [12:0] G = 13'(GRID);
  logic [SENS_SHIFT-1:0] r_res, w_res;
  logic signed [11:0] w_acc, w_step;
  logic signed [12:0] w_st, w_sum;
  logic [W-1:0] w_pos;
  always_comb begin
    w_acc = $signed({{(12 - SENS_SHIFT){1'b0}}, r_res}) + 12'(i_delta);
    w_step = w_acc >>> SENS_SHIFT;
    w_st = 13'(w_step);
    w_res = w_acc[SENS_SHIFT-1:0];
`ifdef CURSOR_WRAP_EN
    w_st = w_st > LIM ? LIM : w_st < -LIM ? -LIM : w_st;
    w_sum = $signed({{(13 - W){1'b0}}, o_pos}) + w_st;
    w_pos = W'(w_sum < 13'sd0 ? w_sum + G : w_sum > LIM ? w_sum - G : w_sum);
`else
    w_sum = $signed({{(13 - W){1'b0}}, o_pos}) + w_st;
    w_pos = W'(w_sum < 13'sd0 ? 13'sd0 : w_sum > LIM ? LIM : w_sum);
    w_res = (w_sum < 13'sd0 || w_sum > LIM) ? '0 : w_res;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pos <= W'(GRID / 2);
      r_res <= '0;
    end else if (i_upd) begin
      o_pos <= w_pos;
      r_res <= w_res;
    end
  end
endmodule

// File: rtl/mouse_cell_tracker.sv
// mouse_cell_tracker: PS/2 3-byte packet framer driving absolute cursor cell and buttons
// Optional CURSOR_WRAP_EN makes the cursor wrap at grid edges instead of clamping.
module mouse_cell_tracker
  import drawing_pkg::*;
#(
  parameter int SCREEN_WIDTH = 160,
  parameter int SCREEN_HEIGHT = 120,
  parameter int CELL_DIMENSION = drawing_pkg::CELL_DIMENSION,
  parameter int SENS_SHIFT = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic iClk,
  input logic iReset,
  mouse_cell_tracker_if.slave bus
);
  localparam int GW = SCREEN_WIDTH / CELL_DIMENSION;
  localparam int GH = SCREEN_HEIGHT / CELL_DIMENSION;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t r_state, w_next;
  logic [7:4] r_flags;
  logic [1:0] r_btn_pend;
  logic [7:0] r_dx;
  logic [TW-1:0] r_timer;
  logic r_armed, r_en_d, r_sync, r_btn_l, r_btn_r;
  logic w_byte, w_in_b0, w_wait, w_ack_drop, w_bad, w_tmo, w_upd;
  logic signed [9:0] w_dx, w_dy;
  // UPD behaves like B0 so a byte arriving during the update starts the next packet
  always_comb begin
    w_byte = bus.iByteValid && bus.iEnable;
    w_in_b0 = r_state == B0 || r_state == UPD;
    w_wait = r_state == B1 || r_state == B2;
    w_ack_drop = w_in_b0 && w_byte && r_armed && bus.iByte == ACK_BYTE;
    w_bad = w_in_b0 && w_byte && !w_ack_drop && !bus.iByte[ST_ONE];
    w_tmo = w_wait && bus.iEnable && !bus.iByteValid && r_timer == TW'(TIMEOUT_CYCLES - 1);
    w_upd = r_state == B2 && w_byte;
    w_next = !bus.iEnable ? B0 :
             w_in_b0 ? ((w_byte && !w_ack_drop && !w_bad) ? B1 : B0) :
             w_tmo ? B0 : !w_byte ? r_state : r_state == B1 ? B2 : UPD;
    w_dx = r_flags[ST_XO] ? '0 : {{2{r_flags[ST_XS]}}, r_dx};
    w_dy = r_flags[ST_YO] ? '0 : -{{2{r_flags[ST_YS]}}, bus.iByte};
  end
  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state <= B0;
      r_flags <= '0;
      r_btn_pend <= '0;
      r_dx <= '0;
      r_timer <= '0;
      r_armed <= 1'b1;
      r_en_d <= 1'b0;
      r_sync <= 1'b0;
      r_btn_l <= 1'b0;
      r_btn_r <= 1'b0;
    end else begin
      r_state <= w_next;
      r_en_d <= bus.iEnable;
      r_sync <= w_bad || w_tmo;
      r_armed <= (bus.iEnable && !r_en_d) || (r_armed && !w_ack_drop);
      r_timer <= (w_byte || !w_wait) ? '0 : r_timer == '1 ? r_timer : r_timer + 1'b1;
      if (w_in_b0 && w_next == B1) begin
        r_flags <= bus.iByte[7:4];
        r_btn_pend <= bus.iByte[1:0];
      end
      if (r_state == B1 && w_byte) r_dx <= bus.iByte;
      if (w_upd) begin
        r_btn_l <= r_btn_pend[ST_L];
        r_btn_r <= r_btn_pend[ST_R];
      end
    end
  end
  axis_accumulator #(.GRID(GW), .SENS_SHIFT(SENS_SHIFT), .W(UPPER_BITS)) u_x (
    .clk(iClk), .rst(iReset), .i_upd(w_upd), .i_delta(w_dx), .o_pos(bus.oX_cell)
  );
  axis_accumulator #(.GRID(GH), .SENS_SHIFT(SENS_SHIFT), .W(UPPER_BITS)) u_y (
    .clk(iClk), .rst(iReset), .i_upd(w_upd), .i_delta(w_dy), .o_pos(bus.oY_cell)
  );
  assign bus.oBtnL = r_btn_l;
  assign bus.oBtnR = r_btn_r;
  assign bus.oPacketValid = r_state == UPD;
  assign bus.oSyncError = r_sync;
endmodule

// File: tb/tb_mouse_cell_tracker.sv
// tb_mouse_cell_tracker: directed packets, reference model feeding a scoreboard of expected updates
module tb_mouse_cell_tracker;
  localparam int TO = 40;
  localparam int SS = 3;
  localparam int GW = 32;
  localparam int GH = 24;
  typedef struct {int x; int y; int l; int r; longint c;} exp_t;
  logic clk = 1'b0;
  logic rst;
  longint cyc = 0;
  longint last_cyc = 0;
  int n_pass = 0, n_total = 0, pv_cnt = 0, se_cnt = 0, pushes = 0;
  int mx = 16, my = 12, rx = 0, ry = 0, ml = 0, mr = 0;
  exp_t q[$];
  mouse_cell_tracker_if bus();
  mouse_cell_tracker #(.TIMEOUT_CYCLES(TO)) dut (.iClk(clk), .iReset(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string t, input longint o, input longint e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s got %0d want %0d", t, o, e);
  endtask
  task automatic axis(input int d, input int g, inout int p, inout int r);
    int a, st;
    a = r + d;
    st = (a >= 0) ? a / (1 << SS) : -((-a + (1 << SS) - 1) / (1 << SS));
    r = a - st * (1 << SS);
`ifdef CURSOR_WRAP_EN
    if (st > g - 1) st = g - 1;
    if (st < 1 - g) st = 1 - g;
    p += st;
    if (p < 0) p += g;
    else if (p >= g) p -= g;
`else
    p += st;
    if (p < 0) begin p = 0; r = 0; end
    else if (p > g - 1) begin p = g - 1; r = 0; end
`endif
  endtask
  task automatic put(input logic [7:0] b);
    @(negedge clk);
    bus.iByte = b;
    bus.iByteValid = 1'b1;
    last_cyc = cyc;
  endtask
  task automatic idle();
    @(negedge clk);
    bus.iByteValid = 1'b0;
  endtask
  task automatic pkt(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy, input bit gap);
    int ddx, ddy;
    put(s);
    if (gap) idle();
    put(dx);
    if (gap) idle();
    put(dy);
    ddx = s[6] ? 0 : (s[4] ? int'(dx) - 256 : int'(dx));
    ddy = s[7] ? 0 : -(s[5] ? int'(dy) - 256 : int'(dy));
    axis(ddx, GW, mx, rx);
    axis(ddy, GH, my, ry);
    ml = int'(s[0]);
    mr = int'(s[1]);
    q.push_back('{mx, my, ml, mr, last_cyc + 1});
    pushes++;
    if (gap) idle();
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.oSyncError) se_cnt++;
    if (bus.oPacketValid) begin
      pv_cnt++;
      chk("pv_expected", longint'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_x", longint'(bus.oX_cell), e.x);
        chk("sb_y", longint'(bus.oY_cell), e.y);
        chk("sb_l", longint'(bus.oBtnL), e.l);
        chk("sb_r", longint'(bus.oBtnR), e.r);
        chk("sb_latency", cyc, e.c);
      end
    end
  end
  initial begin
    rst = 1'b1;
    bus.iEnable = 1'b1;
    bus.iByteValid = 1'b0;
    bus.iByte = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_x", longint'(bus.oX_cell), 16);
    chk("rst_y", longint'(bus.oY_cell), 12);
    chk("rst_l", longint'(bus.oBtnL), 0);
    chk("rst_r", longint'(bus.oBtnR), 0);
    chk("rst_pv", longint'(bus.oPacketValid), 0);
    chk("rst_se", longint'(bus.oSyncError), 0);
    pkt(8'h09, 8'h10, 8'h00, 1'b1);
    chk("p1_x", longint'(bus.oX_cell), 18);
    chk("p1_l", longint'(bus.oBtnL), 1);
    chk("p1_pv", longint'(bus.oPacketValid), 1);
    idle();
    chk("p1_pv_end", longint'(bus.oPacketValid), 0);
    repeat (4) pkt(8'h08, 8'h03, 8'h00, 1'b1);
    chk("frac_x", longint'(bus.oX_cell), 19);
    pkt(8'h28, 8'h00, 8'hC0, 1'b1);
    chk("up_y", longint'(bus.oY_cell), 20);
    pkt(8'h28, 8'h00, 8'hC0, 1'b1);
`ifdef CURSOR_WRAP_EN
    chk("edge_y", longint'(bus.oY_cell), 4);
`else
    chk("edge_y", longint'(bus.oY_cell), 23);
`endif
    put(8'h00);
    idle();
    chk("sync_pulse", longint'(bus.oSyncError), 1);
    idle();
    chk("sync_end", longint'(bus.oSyncError), 0);
    bus.iEnable = 1'b0;
    put(8'h00);
    idle();
    chk("dis_no_sync", longint'(bus.oSyncError), 0);
    put(8'h08);
    idle();
    bus.iEnable = 1'b1;
    idle();
    put(8'hFA);
    idle();
    chk("ack_no_sync", longint'(bus.oSyncError), 0);
    pkt(8'h0A, 8'h00, 8'h00, 1'b1);
    chk("ack_r", longint'(bus.oBtnR), 1);
    chk("ack_x_held", longint'(bus.oX_cell), 19);
    put(8'h08);
    idle();
    put(8'h05);
    idle();
    repeat (TO - 1) idle();
    chk("tmo_early", longint'(bus.oSyncError), 0);
    idle();
    chk("tmo_pulse", longint'(bus.oSyncError), 1);
    idle();
    pkt(8'h08, 8'h08, 8'h00, 1'b1);
    chk("tmo_next_x", longint'(bus.oX_cell), 20);
    pkt(8'h49, 8'hFF, 8'h00, 1'b1);
    chk("ovf_x", longint'(bus.oX_cell), 20);
    chk("ovf_l", longint'(bus.oBtnL), 1);
    chk("ovf_pv", longint'(bus.oPacketValid), 1);
    pkt(8'h08, 8'h01, 8'h00, 1'b0);
    pkt(8'h09, 8'h02, 8'h00, 1'b0);
    idle();
    repeat (3) idle();
    chk("queue_empty", longint'(q.size()), 0);
    chk("pv_count", pv_cnt, pushes);
    chk("se_count", se_cnt, 2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mouse_cell_tracker.md
# mouse_cell_tracker

Upstream feeder of the drawing integrated circuit. Consumes raw bytes from the PS/2 receiver, assembles standard 3-byte mouse packets, and converts relative motion into an absolute cursor cell position on the drawing grid (each cell = CELL_DIMENSION x CELL_DIMENSION pixels). Drives the circuit's `iX_cell`, `iY_cell`, `iBtnL` and `iBtnR` inputs, and is gated by the circuit's `oEnableMouse`.

## Interface
Parameters:
- `SCREEN_WIDTH`, 160, display width in pixels
- `SCREEN_HEIGHT`, 120, display height in pixels
- `CELL_DIMENSION`, 5, pixels per cell side; GRID_W = 32, GRID_H = 24 at defaults
- `SENS_SHIFT`, 3, mouse counts per cell = 2^SENS_SHIFT
- `TIMEOUT_CYCLES`, 50000, max idle cycles between bytes of one packet

Ports:
- `iClk`  in  1  clock; the only clock in the block
- `iReset`  in  1  synchronous, active-high reset
- `iByte`  in  8  received PS/2 byte
- `iByteValid`  in  1  one-cycle strobe, `iByte` valid
- `iEnable`  in  1  from circuit `oEnableMouse`; streaming active
- `oX_cell`  out  UPPER_BITS  cursor cell column, 0..GRID_W-1
- `oY_cell`  out  UPPER_BITS  cursor cell row, 0..GRID_H-1 (0 = top)
- `oBtnL`, `oBtnR`  out  1 each  button levels from last accepted packet
- `oPacketValid`  out  1  one-cycle pulse on each position/button update
- `oSyncError`  out  1  one-cycle pulse when a byte is discarded for framing

UPPER_BITS = clog2(max(GRID_W, GRID_H)), identical to the integrated circuit's definition.

## Operation
- FSM states: `B0`, `B1`, `B2`, `UPD`. Reset -> `B0`.
- `B0`: on `iByteValid`, accept only if `iByte[3]==1`; else pulse `oSyncError`, stay. Accepted byte latched as status -> `B1`.
- Ack filter: after `iEnable` rises, the first byte equal to 0xFA in `B0` is silently dropped (no `oSyncError`).
- `B1`: byte latched as dx -> `B2`. `B2`: byte latched as dy -> `UPD`.
- `UPD` (one cycle): apply motion, latch buttons (status bit0 = L, bit1 = R), pulse `oPacketValid`, -> `B0`.
- Deltas: 9-bit signed, sign = status bit4 (X) / bit5 (Y). Overflow bit6 (X) / bit7 (Y) set -> that axis delta forced to 0; buttons still update.
- Y is negated (PS/2 positive = up; grid row 0 = top).
- Per axis: acc = residue + delta (signed, 12 bits); cell_step = acc >>> SENS_SHIFT (floor); residue = acc - (cell_step << SENS_SHIFT), always in [0, 2^SENS_SHIFT).
- New position = pos + cell_step clamped to [0, GRID-1]; if clamping occurred, residue cleared to 0.
- `iEnable` low: every state -> `B0`, bytes ignored, no pulses; position, buttons and residues held.
- Timeout: in `B1`/`B2`, TIMEOUT_CYCLES cycles without `iByteValid` -> `B0`, partial packet dropped, `oSyncError` pulses once.

## Timing
- Reset values: `oX_cell` = GRID_W/2 (16), `oY_cell` = GRID_H/2 (12), buttons 0, pulses 0, residues 0, ack filter armed.
- Latency: outputs update and `oPacketValid` asserts in the cycle after the third byte's `iByteValid` (registered, 1 cycle).
- Outputs change only in `UPD`; stable otherwise.
- `iByteValid` during `UPD` is accepted as the next packet's byte 0 (evaluated in parallel with the update).
- Timeout counter resets on every accepted byte; saturates, never wraps.
- Reset mid-packet: partial packet discarded, all outputs return to reset values next cycle.

## Configuration
- `CURSOR_WRAP_EN` defined: boundaries wrap instead of clamp. cell_step is first clamped to [-(GRID-1), GRID-1], then one conditional add/subtract of GRID; residue is preserved across a wrap.
- Undefined: clamp behaviour as in Operation.

## Structure
- Shared package `drawing_pkg`: CELL_DIMENSION, GRID_W/GRID_H/UPPER_BITS derivations, FSM state enum, PS/2 status-bit index constants, ACK byte 0xFA.
- One sub-module `axis_accumulator` (params GRID, SENS_SHIFT), instantiated for X and Y: residue register, floor-shift step, clamp/wrap, position register.

## Test plan
- Reset, then packet 0x09, 0x10, 0x00 (L down, dx=+16) -> oX_cell=18, oY_cell=12, oBtnL=1, one `oPacketValid` pulse one cycle after the third byte.
- Four packets of dx=+3 -> position steps +0,+0,+1,+0 (acc 3,6,9->1,4); residue carries across packets.
- Status 0x28 with dy=0xC0 (dy=-64, up-negated -> +8 rows) from row 12 -> row 20; repeat -> row 23, residue 0 (clamp); with `CURSOR_WRAP_EN` -> row 4.
- Byte 0x00 in `B0` -> `oSyncError` pulse, state stays `B0`; enable rise then 0xFA -> dropped, no pulse; next valid packet decodes normally.
- Bytes 0x08, 0x05, then TIMEOUT_CYCLES idle -> `oSyncError` pulse, no update; subsequent 3-byte packet decodes correctly.
- Status 0x48 (X overflow) dx=0xFF -> oX_cell unchanged, buttons updated, `oPacketValid` pulses.
